sd_cmd_phy_ctrl: RTL and testbench
==================================

# sd_cmd_phy_ctrl

Parametrised SD command-line engine. Sits between the host command register block and the bidirectional CMD pad. Accepts one command per handshake and generates start bit, index, argument, CRC7 and end bit. Optionally captures a 48-bit or 136-bit response with timeout, CRC, index and end-bit checking, then enforces the N_CC gap before signalling completion.

## Interface
Parameters:
- INIT_CYCLES, 74: clocks of CMD driven high after reset before the first command.
- NCR_MAX, 64: response start-bit timeout, in clocks after the command end bit.
- NCC_CYCLES, 8: idle clocks after the response (or command, if none) before `done_o`.
- BUSY_MAX, 65535: DAT0 busy timeout in clocks (used only with the busy feature).

Ports:
- SD_CLK_IN  in  1  clock; all logic on the rising edge.
- RST_IN  in  1  reset, asynchronous, active-high.
- start_i  in  1  command request; accepted only while `ready_o`=1.
- cmd_index_i  in  6  command index.
- cmd_arg_i  in  32  argument.
- resp_type_i  in  2  00 none, 01 short (48-bit), 10 long (136-bit), 11 short with busy.
- chk_crc_i  in  1  enables response CRC check.
- chk_idx_i  in  1  enables response index check.
- abort_i  in  1  synchronous abort.
- ready_o  out  1  high in IDLE only.
- done_o  out  1  one-cycle completion pulse.
- status_o  out  5  {abort, busy_to, end_err, idx_err, crc_err, timeout} minus busy_to without the feature; see Configuration. Held until the next accepted start.
- resp_o  out  120  short: [37:0]=index+argument, [119:38]=0; long: [119:0]=R2 bits 127..8.
- cmd_i  in  1  CMD pad input.
- cmd_out_o  out  1  CMD pad output.
- cmd_oe_o  out  1  CMD pad output enable.
- dat0_i  in  1  DAT0 pad input (busy sense).

## Operation
- States: INIT, IDLE, SEND, NCR, RECV, BUSY, GAP.
- INIT: `cmd_oe_o`=1, `cmd_out_o`=1 for INIT_CYCLES clocks, then IDLE.
- IDLE: `cmd_oe_o`=0. On `start_i`, latch all request inputs, clear `status_o` and `resp_o`, and go to SEND.
- SEND: 48 clocks, MSB first: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1.
  - CRC7 uses G(x)=x^7+x^3+1 over the first 40 bits and is computed internally.
- After SEND: resp_type 00 goes to GAP; otherwise NCR.
- NCR: `cmd_oe_o`=0.
  - `cmd_i` is sampled each clock starting with the 2nd clock; the first 0 is the start bit, then go to RECV.
  - If the counter reaches NCR_MAX, set timeout and go to GAP.
- RECV: shift the remaining 47 or 135 bits.
  - Short: CRC over bits 47..8, compared with bits 7..1. Index compared with the latched index.
  - Long: CRC over bits 127..8 only. The index check is skipped.
  - Bit 0 ≠ 1 sets end_err.
  - Then go to BUSY if resp_type=11 (and the feature is built), else GAP.
- BUSY: wait for `dat0_i`=1. BUSY_MAX clocks without release set busy_to, then GAP.
- GAP: `cmd_oe_o`=0 for NCC_CYCLES clocks. `done_o` pulses on the last GAP clock, then IDLE.
- abort_i in SEND/NCR/RECV/BUSY:
  - `cmd_oe_o` drops next clock; abort is set; go to GAP.
  - abort_i is ignored in INIT, IDLE and GAP.
- Counters saturate. No wrap-around is permitted.

## Timing
- Reset values:
  - `cmd_oe_o`=1, `cmd_out_o`=1.
  - `ready_o`=0, `done_o`=0.
  - `status_o`=0, `resp_o`=0.
  - state INIT.
- RST_IN asserted mid-operation returns the block to INIT and re-runs INIT_CYCLES.
- `cmd_out_o`/`cmd_oe_o` are registered. The start bit is driven on the clock after the acceptance clock.
- `start_i` together with `ready_o` high in the same clock means accepted. `ready_o` drops on the next clock.
- `start_i` while not ready is ignored, never queued.
- `resp_o`/`status_o` are valid when `done_o`=1 and stable until the next accept.
- Latency:
  - No-response command: done = 1 + 48 + NCC_CYCLES clocks after accept.
  - Short response with start bit at NCR clock k: done = 1 + 48 + k + 47 + NCC_CYCLES clocks after accept.
- abort_i and timeout in the same clock: both flags set.

## Configuration
- `SD_CMD_BUSY_WAIT_EN` defined:
  - BUSY state, `dat0_i` and busy_to are present.
  - `status_o` is 6 bits: {abort, busy_to, end_err, idx_err, crc_err, timeout}.
- Undefined:
  - resp_type 11 is treated as 01.
  - `dat0_i` is unused.
  - `status_o` is 5 bits: {abort, end_err, idx_err, crc_err, timeout}.

## Test plan
- After reset: `cmd_out_o`=1, `cmd_oe_o`=1 for exactly 74 clocks, then `ready_o`=1.
- CMD0, arg 0, type 00 -> serial 0x400000000095; `done_o` 57 clocks after accept; status 0.
- CMD8, arg 0x1AA, type 01; card replies 0x0800_0001AA_13 at NCR clock 5 -> `resp_o`[37:0]=0x08000001AA; status 0.
- CMD55, arg 0; reply 0x37_00000120_83 -> status 0. Same reply with one bit flipped -> crc_err only. Reply index 0x36 with correct CRC -> idx_err only.
- Type 01 with `cmd_i` held 1 -> timeout after 64 clocks; `done_o` 8 clocks later.
- Type 11 with the feature: `dat0_i` low for 100 clocks after the end bit -> done at release + 8, status 0. `abort_i` during SEND bit 20 -> `cmd_oe_o`=0 next clock; abort set.

Source files
------------

// File: rtl/sd_cmd_phy_ctrl.sv
// SD CMD-line engine: command framing with CRC7, response capture/checks and N_CC gap.
// Define SD_CMD_BUSY_WAIT_EN to build the DAT0 busy wait and the busy_to status flag.
module sd_cmd_phy_ctrl #(
  parameter int unsigned INIT_CYCLES = 74,
  parameter int unsigned NCR_MAX     = 64,
  parameter int unsigned NCC_CYCLES  = 8,
  parameter int unsigned BUSY_MAX    = 65535
) (
  input  logic         SD_CLK_IN,
  input  logic         RST_IN,
  input  logic         start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  input  logic         chk_crc_i,
  input  logic         chk_idx_i,
  input  logic         abort_i,
  output logic         ready_o,
  output logic         done_o,
`ifdef SD_CMD_BUSY_WAIT_EN
  output logic [5:0]   status_o,
`else
  output logic [4:0]   status_o,
`endif
  output logic [119:0] resp_o,
  input  logic         cmd_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  input  logic         dat0_i
);

  localparam int unsigned M1     = (INIT_CYCLES > 134) ? INIT_CYCLES : 134;
  localparam int unsigned M2     = (NCR_MAX > M1) ? NCR_MAX : M1;
  localparam int unsigned M3     = (NCC_CYCLES > M2) ? NCC_CYCLES : M2;
  localparam int unsigned CntMax = (BUSY_MAX > M3) ? BUSY_MAX : M3;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
`ifdef SD_CMD_BUSY_WAIT_EN
  localparam int unsigned StW = 6;
`else
  localparam int unsigned StW = 5;
`endif

  typedef enum logic [2:0] {StInit, StIdle, StSend, StNcr, StRecv, StBusy, StGap} state_e;

  state_e         r_state, w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [5:0]     r_idx;
  logic [1:0]     r_type;
  logic           r_chk_crc, r_chk_idx;
  logic [46:0]    r_tx;
  logic [6:0]     r_crc, r_rx_crc;
  logic [119:0]   r_resp;
  logic [StW-1:0] r_status;
  logic           r_cmd_out, r_cmd_oe;

  logic [1:0]     w_type;
  logic [47:0]    w_frame;
  logic           w_accept, w_abort, w_start_bit, w_ncr_to, w_gap_last;
  logic           w_long, w_busy, w_busy_exit;
  logic [CntW-1:0] w_hi_data, w_hi_crc;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

`ifdef SD_CMD_BUSY_WAIT_EN
  logic w_busy_to;
  assign w_type      = resp_type_i;
  assign w_busy      = (r_type == 2'b11);
  assign w_busy_to   = (r_state == StBusy) && !dat0_i && (r_cnt == CntW'(BUSY_MAX - 1));
  assign w_busy_exit = dat0_i || w_busy_to;
`else
  logic w_unused_dat0;
  assign w_type        = (resp_type_i == 2'b11) ? 2'b01 : resp_type_i;
  assign w_busy        = 1'b0;
  assign w_busy_exit   = 1'b1;
  assign w_unused_dat0 = dat0_i;
`endif

  assign w_frame     = {2'b01, cmd_index_i, cmd_arg_i,
                        crc7_40({2'b01, cmd_index_i, cmd_arg_i}), 1'b1};
  assign w_accept    = (r_state == StIdle) && start_i;
  assign w_abort     = abort_i && (r_state inside {StSend, StNcr, StRecv, StBusy});
  // The first NCR clock is never sampled for the start bit.
  assign w_start_bit = (r_state == StNcr) && (r_cnt != '0) && !cmd_i;
  assign w_ncr_to    = (r_state == StNcr) && !w_start_bit && (r_cnt == CntW'(NCR_MAX - 1));
  assign w_gap_last  = (r_state == StGap) && (r_cnt == CntW'(NCC_CYCLES - 1));
  assign w_long      = (r_type == 2'b10);
  assign w_hi_data   = w_long ? CntW'(127) : CntW'(45);
  assign w_hi_crc    = w_long ? CntW'(127) : CntW'(46);

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) r_state <= StInit;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StInit: if (r_cnt == CntW'(INIT_CYCLES - 1)) w_state_d = StIdle;
      StIdle: if (start_i) w_state_d = StSend;
      StSend: if (r_cnt == CntW'(47)) w_state_d = (r_type == 2'b00) ? StGap : StNcr;
      StNcr: begin
        if (w_start_bit)   w_state_d = StRecv;
        else if (w_ncr_to) w_state_d = StGap;
      end
      StRecv: if (r_cnt == '0) w_state_d = w_busy ? StBusy : StGap;
      StBusy: if (w_busy_exit) w_state_d = StGap;
      StGap:  if (w_gap_last) w_state_d = StIdle;
      default: w_state_d = StInit;
    endcase
    if (w_abort) w_state_d = StGap;
  end

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_type    <= '0;
      r_chk_crc <= 1'b0;
      r_chk_idx <= 1'b0;
      r_tx      <= '0;
      r_crc     <= '0;
      r_rx_crc  <= '0;
      r_resp    <= '0;
      r_status  <= '0;
      r_cmd_out <= 1'b1;
      r_cmd_oe  <= 1'b1;
    end else begin
      r_cmd_oe  <= (w_state_d == StInit) || (w_state_d == StSend);
      r_cmd_out <= 1'b1;
      // RECV counts down the remaining bit position; every other state counts up.
      if (w_state_d != r_state) begin
        r_cnt <= (w_state_d == StRecv) ? (w_long ? CntW'(134) : CntW'(46)) : '0;
      end else if (r_state == StRecv) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_idx     <= cmd_index_i;
        r_type    <= w_type;
        r_chk_crc <= chk_crc_i;
        r_chk_idx <= chk_idx_i;
        r_tx      <= w_frame[46:0];
        r_cmd_out <= w_frame[47];
        r_crc     <= '0;
        r_rx_crc  <= '0;
        r_resp    <= '0;
        r_status  <= '0;
      end
      if (r_state == StSend) begin
        if (w_state_d == StSend) r_cmd_out <= r_tx[46];
        r_tx <= {r_tx[45:0], 1'b1};
      end
      if (r_state == StRecv) begin
        if (r_cnt >= CntW'(8) && r_cnt <= w_hi_data) r_resp <= {r_resp[118:0], cmd_i};
        if (r_cnt >= CntW'(8) && r_cnt <= w_hi_crc) r_crc <= crc7_step(r_crc, cmd_i);
        if (r_cnt >= CntW'(1) && r_cnt <= CntW'(7)) r_rx_crc <= {r_rx_crc[5:0], cmd_i};
        if (r_cnt == '0) begin
          r_status[1] <= r_status[1] | (r_chk_crc && (r_crc != r_rx_crc));
          r_status[2] <= r_status[2] | (!w_long && r_chk_idx && (r_resp[37:32] != r_idx));
          r_status[3] <= r_status[3] | !cmd_i;
        end
      end
      if (w_ncr_to) r_status[0] <= 1'b1;
`ifdef SD_CMD_BUSY_WAIT_EN
      if (w_busy_to) r_status[4] <= 1'b1;
`endif
      if (w_abort) r_status[StW-1] <= 1'b1;
    end
  end

  always_comb begin
    ready_o   = (r_state == StIdle);
    done_o    = w_gap_last;
    cmd_out_o = r_cmd_out;
    cmd_oe_o  = r_cmd_oe;
    status_o  = r_status;
    resp_o    = r_resp;
  end

endmodule

// File: tb/tb_sd_cmd_phy_ctrl.sv
// Directed bench for sd_cmd_phy_ctrl: framing, latency, response checks, abort and reset.
module tb_sd_cmd_phy_ctrl;
`ifdef SD_CMD_BUSY_WAIT_EN
  localparam int SW = 6;
`else
  localparam int SW = 5;
`endif
  localparam int AB = SW - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    cmd_index = '0;
  logic [31:0]   cmd_arg = '0;
  logic [1:0]    resp_type = '0;
  logic          chk_crc = 1'b1;
  logic          chk_idx = 1'b1;
  logic          abort = 1'b0;
  logic          ready, done;
  logic [SW-1:0] status;
  logic [119:0]  resp;
  logic          cmd_in = 1'b1;
  logic          cmd_out, cmd_oe;
  logic          dat0 = 1'b1;

  int            n_assert = 0;
  int            n_fail = 0;
  logic [47:0]   ser;
  int            done_at, oe_cnt, n;
  logic          oe_ab;
  logic [135:0]  rsp;
  logic [119:0]  payload;

  always #5 clk = ~clk;

  sd_cmd_phy_ctrl dut (
    .SD_CLK_IN   (clk),
    .RST_IN      (rst),
    .start_i     (start),
    .cmd_index_i (cmd_index),
    .cmd_arg_i   (cmd_arg),
    .resp_type_i (resp_type),
    .chk_crc_i   (chk_crc),
    .chk_idx_i   (chk_idx),
    .abort_i     (abort),
    .ready_o     (ready),
    .done_o      (done),
    .status_o    (status),
    .resp_o      (resp),
    .cmd_i       (cmd_in),
    .cmd_out_o   (cmd_out),
    .cmd_oe_o    (cmd_oe),
    .dat0_i      (dat0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7_n(input logic [127:0] d, input int len);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = len - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Counts cycles with CMD driven high, starting at the reset-release cycle.
  task automatic init_count(output int cnt);
    int iter;
    cnt  = 0;
    iter = 0;
    while (!ready && iter < 300) begin
      if (cmd_oe && cmd_out) cnt++;
      @(negedge clk);
      iter++;
    end
  endtask

  // Cycle 1 is the accept cycle; SEND occupies cycles 2..49, NCR clock j is cycle 49+j.
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                        input logic [135:0] r, input int rlen, input int k,
                        input int busy_lo, input int abort_at);
    int cyc, w, e;
    w = 0;
    while (!ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 128'(ready), 128'(1'b1));
    start     = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    resp_type = typ;
    ser       = '0;
    done_at   = -1;
    oe_cnt    = 0;
    oe_ab     = 1'bx;
    e         = 49 + k + rlen - 1;
    cyc       = 1;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        done_at = cyc;
        break;
      end
      if (cyc >= 2 && cyc <= 49) ser = {ser[46:0], cmd_out & cmd_oe};
      if (cmd_oe) oe_cnt++;
      if (cyc == abort_at + 1) oe_ab = cmd_oe;
      abort = (cyc == abort_at);
      if (rlen > 0 && cyc >= 49 + k && cyc <= e) cmd_in = r[e - cyc];
      else cmd_in = 1'b1;
      dat0 = !(cyc > e && cyc <= e + busy_lo);
    end
    abort  = 1'b0;
    cmd_in = 1'b1;
    dat0   = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_oe", 128'(cmd_oe), 128'(1'b1));
    check("rst_out", 128'(cmd_out), 128'(1'b1));
    check("rst_ready", 128'(ready), 128'(1'b0));
    check("rst_done", 128'(done), 128'(1'b0));
    check("rst_status", 128'(status), 128'(0));
    check("rst_resp", 128'(resp), 128'(0));
    rst = 1'b0;
    init_count(n);
    check("init_cycles", 128'(n), 128'(74));
    check("init_ready", 128'(ready), 128'(1'b1));
    check("idle_oe", 128'(cmd_oe), 128'(1'b0));

    // CMD0, no response
    do_cmd(6'd0, 32'h0, 2'b00, '0, 0, 0, 0, -1);
    check("cmd0_serial", 128'(ser), 128'(48'h400000000095));
    check("cmd0_done_at", 128'(done_at), 128'(57));
    check("cmd0_oe_cycles", 128'(oe_cnt), 128'(48));
    check("cmd0_status", 128'(status), 128'(0));
    @(negedge clk);
    check("done_one_cycle", 128'(done), 128'(1'b0));
    check("ready_after_done", 128'(ready), 128'(1'b1));

    // CMD8 with R7 reply at NCR clock 5
    do_cmd(6'd8, 32'h1AA, 2'b01, 136'(48'h08000001AA13), 48, 5, 0, -1);
    check("cmd8_serial", 128'(ser), 128'(48'h48000001AA87));
    check("cmd8_done_at", 128'(done_at), 128'(109));
    check("cmd8_resp", 128'(resp), 128'(120'h8000001AA));
    check("cmd8_status", 128'(status), 128'(0));

    // CMD55: good reply, flipped argument bit, wrong index with valid CRC
    do_cmd(6'd55, 32'h0, 2'b01, 136'(48'h370000012083), 48, 3, 0, -1);
    check("cmd55_done_at", 128'(done_at), 128'(107));
    check("cmd55_status", 128'(status), 128'(0));
    do_cmd(6'd55, 32'h0, 2'b01, 136'(48'h370000012083 ^ 48'h100000), 48, 3, 0, -1);
    check("cmd55_crc_err", 128'(status), 128'(5'b00010));
    rsp = 136'({8'h36, 32'h120, crc7_n(128'({8'h36, 32'h120}), 40), 1'b1});
    do_cmd(6'd55, 32'h0, 2'b01, rsp, 48, 4, 0, -1);
    check("cmd55_idx_err", 128'(status), 128'(5'b00100));
    check("cmd55_idx_done_at", 128'(done_at), 128'(108));

    // Long R2 reply: index field is not checked, CRC covers bits 127..8
    payload = 120'h0123456789ABCDEFFEDCBA98765432;
    rsp = {8'h3F, payload, crc7_n(128'(payload), 120), 1'b1};
    do_cmd(6'd2, 32'h0, 2'b10, rsp, 136, 2, 0, -1);
    check("r2_done_at", 128'(done_at), 128'(194));
    check("r2_resp", 128'(resp), 128'(payload));
    check("r2_status", 128'(status), 128'(0));

    // No start bit: timeout after 64 NCR clocks, done 8 clocks later
    do_cmd(6'd8, 32'h1AA, 2'b01, '0, 0, 0, 0, -1);
    check("timeout_done_at", 128'(done_at), 128'(121));
    check("timeout_status", 128'(status), 128'(5'b00001));

    // End bit 0
    do_cmd(6'd8, 32'h1AA, 2'b01, 136'(48'h08000001AA12), 48, 2, 0, -1);
    check("end_err_status", 128'(status), 128'(5'b01000));
    check("end_err_done_at", 128'(done_at), 128'(106));

    // Type 11: busy held for 100 clocks after the end bit
    do_cmd(6'd8, 32'h1AA, 2'b11, 136'(48'h08000001AA13), 48, 5, 100, -1);
`ifdef SD_CMD_BUSY_WAIT_EN
    check("busy_done_at", 128'(done_at), 128'(210));
`else
    check("r1b_as_r1_done_at", 128'(done_at), 128'(109));
`endif
    check("busy_status", 128'(status), 128'(0));

    // Abort during SEND bit 20
    do_cmd(6'd0, 32'h0, 2'b01, '0, 0, 0, 0, 22);
    check("abort_oe_next", 128'(oe_ab), 128'(1'b0));
    check("abort_done_at", 128'(done_at), 128'(30));
    check("abort_oe_cycles", 128'(oe_cnt), 128'(21));
    check("abort_status", 128'(status), 128'(1 << AB));

    // Abort on the last NCR clock: abort and timeout together
    do_cmd(6'd8, 32'h1AA, 2'b01, '0, 0, 0, 0, 113);
    check("abort_to_status", 128'(status), 128'((1 << AB) | 1));
    check("abort_to_done_at", 128'(done_at), 128'(121));

    // Reset mid-command re-runs INIT; start held during INIT is not queued
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    start     = 1'b1;
    resp_type = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_oe", 128'(cmd_oe), 128'(1'b1));
    check("midrst_ready", 128'(ready), 128'(1'b0));
    check("midrst_status", 128'(status), 128'(0));
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    init_count(n);
    start = 1'b0;
    check("reinit_cycles", 128'(n), 128'(74));
    @(negedge clk);
    check("start_not_queued", 128'(ready), 128'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
